// File: rtl/dmc_sample_unit.sv
// DMC sample reader and delta output unit.
// Fetches sample bytes by DMA and turns bits into +/-2 level steps.
module dmc_sample_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        step,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        ctrl_we,
  input  logic        ctrl_enable,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  input  logic        dma_ack,
  input  logic [7:0]  dma_data,
  output logic [6:0]  level,
  output logic        irq,
  output logic        active
);

  logic [6:0]  r_level;
  logic        r_irq;
  logic        r_irq_en;
  logic        r_loop;
  logic [15:0] r_start_addr;
  logic [11:0] r_sample_len;
  logic [15:0] r_cur_addr;
  logic [11:0] r_bytes_rem;
  logic        r_dma_req;
  logic [7:0]  r_sample_buf;
  logic        r_buf_full;
  logic [7:0]  r_shift;
  logic [3:0]  r_bits_left;
  logic        r_silence;

  logic        w_wr_4010;
  logic        w_wr_4011;
  logic        w_wr_4012;
  logic        w_wr_4013;
  logic        w_disable;
  logic        w_ack;
  logic        w_issue;
  logic        w_rem_nz;
  logic        w_last;
  logic [15:0] w_next_addr;

  assign w_wr_4010 = reg_we && (reg_addr == 2'd0);
  assign w_wr_4011 = reg_we && (reg_addr == 2'd1);
  assign w_wr_4012 = reg_we && (reg_addr == 2'd2);
  assign w_wr_4013 = reg_we && (reg_addr == 2'd3);
  assign w_disable = ctrl_we && !ctrl_enable;
  assign w_ack     = dma_ack && r_dma_req && !w_disable;
  assign w_rem_nz  = (r_bytes_rem != 12'd0);
  assign w_issue   = !r_dma_req && !r_buf_full && w_rem_nz;
  assign w_last    = (r_bytes_rem == 12'd1);
  // Sample space wraps back into the upper half of memory.
  assign w_next_addr = (r_cur_addr == 16'hFFFF) ? 16'h8000
                                                : r_cur_addr + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level      <= 7'd0;
      r_irq        <= 1'b0;
      r_irq_en     <= 1'b0;
      r_loop       <= 1'b0;
      r_start_addr <= 16'hC000;
      r_sample_len <= 12'd1;
      r_cur_addr   <= 16'hC000;
      r_bytes_rem  <= 12'd0;
      r_dma_req    <= 1'b0;
      r_sample_buf <= 8'd0;
      r_buf_full   <= 1'b0;
      r_shift      <= 8'd0;
      r_bits_left  <= 4'd8;
      r_silence    <= 1'b1;
    end else if (cpu_en) begin
      if (step) begin
        if (!r_silence && r_shift[0] && r_level <= 7'd125)
          r_level <= r_level + 7'd2;
        else if (!r_silence && !r_shift[0] && r_level >= 7'd2)
          r_level <= r_level - 7'd2;
        r_shift <= r_shift >> 1;
        if (r_bits_left == 4'd1) begin
          r_bits_left <= 4'd8;
          if (r_buf_full) begin
            r_shift    <= r_sample_buf;
            r_silence  <= 1'b0;
            r_buf_full <= 1'b0;
          end else begin
            r_silence <= 1'b1;
          end
        end else begin
          r_bits_left <= r_bits_left - 4'd1;
        end
      end

      if (w_wr_4011)
        r_level <= reg_wdata[6:0];

      if (w_issue)
        r_dma_req <= 1'b1;

      // An acked byte always lands in the buffer, even if a step drained it.
      if (w_ack) begin
        r_sample_buf <= dma_data;
        r_buf_full   <= 1'b1;
        r_dma_req    <= 1'b0;
        r_cur_addr   <= w_next_addr;
        r_bytes_rem  <= r_bytes_rem - 12'd1;
        if (w_last) begin
          if (r_loop) begin
            r_cur_addr  <= r_start_addr;
            r_bytes_rem <= r_sample_len;
          end else if (r_irq_en) begin
            r_irq <= 1'b1;
          end
        end
      end

      if (w_wr_4010) begin
        r_irq_en <= reg_wdata[7];
        r_loop   <= reg_wdata[6];
        if (!reg_wdata[7])
          r_irq <= 1'b0;
      end
      if (w_wr_4012)
        r_start_addr <= 16'hC000 + {2'b00, reg_wdata, 6'b000000};
      if (w_wr_4013)
        r_sample_len <= {reg_wdata, 4'b0000} + 12'd1;

      if (ctrl_we) begin
        r_irq <= 1'b0;
        if (!ctrl_enable) begin
          r_bytes_rem <= 12'd0;
          r_dma_req   <= 1'b0;
        end else if (!w_rem_nz) begin
          r_cur_addr  <= r_start_addr;
          r_bytes_rem <= r_sample_len;
        end
      end
    end
  end

  assign dma_req  = r_dma_req;
  assign dma_addr = r_cur_addr;
  assign level    = r_level;
  assign irq      = r_irq;
  assign active   = w_rem_nz;

endmodule

// File: tb/tb_dmc_sample_unit.sv
// Bench for dmc_sample_unit: vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_dmc_sample_unit;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        step;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        ctrl_we;
  logic        ctrl_enable;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_data;
  logic [6:0]  level;
  logic        irq;
  logic        active;

  int total;
  int bad;

  dmc_sample_unit dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .step       (step),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .ctrl_we    (ctrl_we),
    .ctrl_enable(ctrl_enable),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_ack    (dma_ack),
    .dma_data   (dma_data),
    .level      (level),
    .irq        (irq),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ab;
    logic [7:0]  d;
    logic [6:0]  lv;
    logic [15:0] ea;
    logic [6:0]  el;
  } vec_t;

  vec_t vt[8];

  // reference model state
  int         m_level;
  bit         m_irq;
  bit         m_irqen;
  bit         m_loop;
  int         m_start;
  int         m_len;
  int         m_addr;
  int         m_rem;
  bit         m_req;
  logic [7:0] m_buf[$];
  int         m_shift;
  int         m_bits;
  bit         m_sil;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic ctl(input logic en);
    ctrl_we     = 1'b1;
    ctrl_enable = en;
    cyc();
    ctrl_we = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    dma_ack  = 1'b1;
    dma_data = d;
    cyc();
    dma_ack = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      step = 1'b1;
      cyc();
    end
    step = 1'b0;
  endtask

  // Wait (optionally stepping) for a request, check its address, ack it.
  task automatic fetch(input logic [7:0] d, input logic [15:0] ea,
                       input bit use_step);
    int n;
    n = 0;
    while (!dma_req && n < 40) begin
      step = use_step;
      cyc();
      n++;
    end
    step = 1'b0;
    if (!dma_req) begin
      chk("fetch_timeout", 32'(dma_req), 32'd1);
    end else begin
      chk("fetch_addr", 32'(dma_addr), 32'(ea));
      ack(d);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_irq   = 0;
    m_irqen = 0;
    m_loop  = 0;
    m_start = 'hC000;
    m_len   = 1;
    m_addr  = 'hC000;
    m_rem   = 0;
    m_req   = 0;
    m_buf.delete();
    m_shift = 0;
    m_bits  = 8;
    m_sil   = 1;
  endtask

  task automatic model_step();
    bit pre_issue;
    int pre_rem;
    int pre_start;
    int pre_len;
    bit dis;
    bit acc;
    int tgt;
    if (reset) begin
      model_reset();
      return;
    end
    if (!cpu_en) return;
    pre_issue = !m_req && m_buf.size() == 0 && m_rem != 0;
    pre_rem   = m_rem;
    pre_start = m_start;
    pre_len   = m_len;
    dis = ctrl_we && !ctrl_enable;
    acc = dma_ack && m_req && !dis;
    if (step) begin
      if (!m_sil) begin
        tgt = m_level + ((m_shift % 2 == 1) ? 2 : -2);
        if (tgt >= 0 && tgt <= 127) m_level = tgt;
      end
      m_shift = m_shift / 2;
      if (m_bits == 1) begin
        m_bits = 8;
        if (m_buf.size() > 0) begin
          m_shift = int'(m_buf.pop_front());
          m_sil   = 0;
        end else begin
          m_sil = 1;
        end
      end else begin
        m_bits--;
      end
    end
    if (reg_we && reg_addr == 2'd1) m_level = int'(reg_wdata[6:0]);
    if (pre_issue) m_req = 1;
    if (acc) begin
      m_buf.push_back(dma_data);
      m_req  = 0;
      m_addr = (m_addr == 'hFFFF) ? 'h8000 : m_addr + 1;
      m_rem--;
      if (m_rem == 0) begin
        if (m_loop) begin
          m_addr = pre_start;
          m_rem  = pre_len;
        end else if (m_irqen) begin
          m_irq = 1;
        end
      end
    end
    if (reg_we && reg_addr == 2'd0) begin
      m_irqen = reg_wdata[7];
      m_loop  = reg_wdata[6];
      if (!reg_wdata[7]) m_irq = 0;
    end
    if (reg_we && reg_addr == 2'd2) m_start = 'hC000 + int'(reg_wdata) * 64;
    if (reg_we && reg_addr == 2'd3) m_len = int'(reg_wdata) * 16 + 1;
    if (ctrl_we) begin
      m_irq = 0;
      if (!ctrl_enable) begin
        m_rem = 0;
        m_req = 0;
      end else if (pre_rem == 0) begin
        m_addr = pre_start;
        m_rem  = pre_len;
      end
    end
  endtask

  initial begin
    logic [26:0] got;
    logic [26:0] want;
    logic [15:0] a;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    cpu_en = 1'b1;
    step = 1'b0;
    reg_we = 1'b0;
    reg_addr = 2'd0;
    reg_wdata = 8'd0;
    ctrl_we = 1'b0;
    ctrl_enable = 1'b0;
    dma_ack = 1'b0;
    dma_data = 8'd0;

    vt[0] = '{8'h01, 8'hFF, 7'h40, 16'hC040, 7'h50};
    vt[1] = '{8'h00, 8'h00, 7'h40, 16'hC000, 7'h30};
    vt[2] = '{8'hFF, 8'hFF, 7'h7E, 16'hFFC0, 7'h7E};
    vt[3] = '{8'h80, 8'h00, 7'h01, 16'hE000, 7'h01};
    vt[4] = '{8'h10, 8'hAA, 7'h40, 16'hC400, 7'h40};
    vt[5] = '{8'h3F, 8'hFF, 7'h79, 16'hCFC0, 7'h7F};
    vt[6] = '{8'h7F, 8'h00, 7'h05, 16'hDFC0, 7'h01};
    vt[7] = '{8'h02, 8'h01, 7'h00, 16'hC080, 7'h00};

    // reset overrides cpu_en=0
    cpu_en = 1'b0;
    do_reset();
    cpu_en = 1'b1;
    chk("rst_outs", 32'({level, irq, active, dma_req, dma_addr}),
        32'({7'd0, 1'b0, 1'b0, 1'b0, 16'hC000}));

    foreach (vt[i]) begin
      do_reset();
      wr(2'd1, 8'(vt[i].lv));
      wr(2'd2, vt[i].ab);
      wr(2'd3, 8'h00);
      ctl(1'b1);
      chk("vec_req_lat", 32'(dma_req), 32'd0);
      cyc();
      chk("vec_req", 32'(dma_req), 32'd1);
      chk("vec_addr", 32'(dma_addr), 32'(vt[i].ea));
      ack(vt[i].d);
      chk("vec_active", 32'(active), 32'd0);
      steps(8);
      chk("vec_silent", 32'(level), 32'(vt[i].lv));
      steps(8);
      chk("vec_level", 32'(level), 32'(vt[i].el));
    end

    // irq raise and both clear paths
    do_reset();
    wr(2'd0, 8'h80);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    ctl(1'b1);
    cyc();
    ack(8'h11);
    chk("irq_set", 32'(irq), 32'd1);
    ctl(1'b1);
    chk("irq_clr_4015", 32'(irq), 32'd0);
    fetch(8'h22, 16'hC000, 1'b1);
    chk("irq_reset2", 32'(irq), 32'd1);
    wr(2'd0, 8'h00);
    chk("irq_clr_4010", 32'(irq), 32'd0);

    // looping 17-byte sample
    do_reset();
    wr(2'd0, 8'h40);
    wr(2'd2, 8'h02);
    wr(2'd3, 8'h01);
    ctl(1'b1);
    for (int k = 0; k < 17; k++) begin
      a = 16'hC080 + 16'(k);
      fetch(8'(k), a, 1'b1);
    end
    chk("loop_active", 32'(active), 32'd1);
    chk("loop_irq", 32'(irq), 32'd0);
    wr(2'd0, 8'h00);
    for (int k = 0; k < 17; k++) begin
      a = 16'hC080 + 16'(k);
      fetch(8'h55, a, 1'b1);
      if (k == 15) chk("loop_len16", 32'(active), 32'd1);
    end
    chk("loop_len17", 32'(active), 32'd0);
    chk("loop_noirq", 32'(irq), 32'd0);

    // address wrap FFFF -> 8000
    do_reset();
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'h04);
    ctl(1'b1);
    for (int k = 0; k < 64; k++) begin
      a = 16'hFFC0 + 16'(k);
      fetch(8'h00, a, 1'b1);
    end
    fetch(8'h00, 16'h8000, 1'b1);

    // $4011 write beats a step in the same cycle
    do_reset();
    wr(2'd1, 8'h40);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    ctl(1'b1);
    cyc();
    ack(8'hFF);
    steps(9);
    chk("pri_pre", 32'(level), 32'h42);
    reg_we = 1'b1;
    reg_addr = 2'd1;
    reg_wdata = 8'h7F;
    step = 1'b1;
    cyc();
    reg_we = 1'b0;
    step = 1'b0;
    chk("pri_4011", 32'(level), 32'h7F);
    steps(1);
    chk("pri_sat", 32'(level), 32'h7F);

    // disable plus ack in the same cycle drops the byte
    do_reset();
    wr(2'd1, 8'h40);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    ctl(1'b1);
    cyc();
    chk("dis_req_up", 32'(dma_req), 32'd1);
    ctrl_we = 1'b1;
    ctrl_enable = 1'b0;
    dma_ack = 1'b1;
    dma_data = 8'hFF;
    cyc();
    ctrl_we = 1'b0;
    dma_ack = 1'b0;
    chk("dis_req", 32'(dma_req), 32'd0);
    chk("dis_active", 32'(active), 32'd0);
    steps(16);
    chk("dis_nobuf", 32'(level), 32'h40);

    // reset aborts an outstanding request
    wr(2'd1, 8'h33);
    wr(2'd0, 8'h80);
    wr(2'd2, 8'h05);
    wr(2'd3, 8'h02);
    ctl(1'b1);
    cyc();
    chk("rst2_req_up", 32'(dma_req), 32'd1);
    reset = 1'b1;
    cpu_en = 1'b0;
    dma_ack = 1'b1;
    cyc();
    reset = 1'b0;
    cpu_en = 1'b1;
    dma_ack = 1'b0;
    chk("rst2_outs", 32'({level, irq, active, dma_req, dma_addr}),
        32'({7'd0, 1'b0, 1'b0, 1'b0, 16'hC000}));
    cyc();
    chk("rst2_idle", 32'({active, dma_req}), 32'd0);

    // random traffic vs reference model
    reset = 1'b1;
    model_step();
    cyc();
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom % 500) == 0;
      cpu_en      = ($urandom % 4) != 0;
      step        = ($urandom % 3) == 0;
      reg_we      = ($urandom % 16) == 0;
      reg_addr    = 2'($urandom);
      reg_wdata   = 8'($urandom);
      ctrl_we     = ($urandom % 40) == 0;
      ctrl_enable = ($urandom % 4) != 0;
      dma_ack     = ($urandom % 3) == 0;
      dma_data    = 8'($urandom);
      model_step();
      cyc();
      got  = {level, irq, active, dma_req, dma_addr};
      want = {7'(m_level), m_irq, (m_rem != 0), m_req, 16'(m_addr)};
      chk("rand", 32'(got), 32'(want));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmc_sample_unit.md
DMC_SAMPLE_UNIT -- requirements
Module: dmc_sample_unit

Interface
REQ-001 SHALL have clock clk and reset reset (synchronous, active-high); all state updates occur on posedge clk.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_en  in  1  CPU-cycle enable; all state updates are gated by cpu_en=1
- step  in  1  output-unit tick from the DMC rate timer (timer reached 0)
- reg_we  in  1  APU register write strobe for $4010-$4013
- reg_addr  in  2  register select: 0=$4010, 1=$4011, 2=$4012, 3=$4013
- reg_wdata  in  8  register write data
- ctrl_we  in  1  $4015 write strobe
- ctrl_enable  in  1  $4015 bit 4
- dma_req  out  1  sample-byte fetch request
- dma_addr  out  16  fetch address
- dma_ack  in  1  fetch complete; dma_data is valid this cycle
- dma_data  in  8  fetched byte
- level  out  7  DAC output level
- irq  out  1  DMC interrupt flag
- active  out  1  bytes_remaining != 0

Function
REQ-003 Every update below SHALL occur only on a clk edge with cpu_en=1; when cpu_en=0 all state holds.
REQ-004 $4010 write: irq_en<=bit7, loop<=bit6; if bit7=0, irq<=0 on the same edge.
REQ-005 $4011 write: level<=reg_wdata[6:0]; this takes priority over any step update in the same cycle.
REQ-006 $4012 write: start_addr<=16'hC000 + {reg_wdata,6'b0}.
REQ-007 $4013 write: sample_len<={reg_wdata,4'b0}+1 (12 bits).
REQ-008 $4015 write: irq<=0. If ctrl_enable=0: bytes_remaining<=0 and dma_req<=0, and a dma_ack in the same cycle is ignored. If ctrl_enable=1 and bytes_remaining=0: cur_addr<=start_addr and bytes_remaining<=sample_len. If ctrl_enable=1 and bytes_remaining!=0: no reload.
REQ-009 The reader SHALL assert dma_req (registered) with dma_addr=cur_addr when buffer_full=0, bytes_remaining!=0 and no request is outstanding; dma_req and dma_addr SHALL be held stable until dma_ack.
REQ-010 On dma_ack with dma_req=1:
- sample_buf<=dma_data; buffer_full<=1; dma_req<=0
- cur_addr<=cur_addr+1, wrapping 16'hFFFF -> 16'h8000
- bytes_remaining decrements
- if the result is 0: if loop=1, reload cur_addr<=start_addr and bytes_remaining<=sample_len; else if irq_en=1, irq<=1
REQ-011 dma_ack without an outstanding dma_req SHALL be ignored.
REQ-012 Output unit state: shift[7:0], bits_left in 1..8, silence. On step:
- if silence=0 and shift[0]=1 and level<=125: level+=2
- if silence=0 and shift[0]=0 and level>=2: level-=2
- otherwise level holds (no wrap past 0 or 127)
- shift>>=1
REQ-013 On step with bits_left=1, a new output cycle SHALL start: bits_left<=8; if buffer_full=1 then shift<=sample_buf, silence<=0, buffer_full<=0; else silence<=1. Otherwise bits_left decrements.
REQ-014 When step empties the buffer and dma_ack arrives in the same cycle: the step uses the old buffer contents, and the acked byte then refills the buffer (buffer_full=1 after the edge). If the buffer was empty at the step, silence<=1 and the acked byte is kept for the next cycle.
REQ-015 active SHALL equal (bytes_remaining!=0) combinationally from the register.

Reset
REQ-016 On reset: level=0, irq=0, dma_req=0, dma_addr/cur_addr=16'hC000, start_addr=16'hC000, sample_len=1, bytes_remaining=0, buffer_full=0, shift=0, bits_left=8, silence=1, irq_en=0, loop=0.
REQ-017 reset SHALL override all other inputs, including cpu_en=0, and SHALL abort any outstanding request.

Verification
REQ-018 Sequence: $4012=0x01, $4013=0x00, $4015 enable -> dma_req=1, dma_addr=0xC040; ack with 0xFF -> active=0; eight steps from level 0x40 -> level steps up to 0x50.
REQ-019 Setup: irq_en=1, loop=0, length 1; ack the fetch -> irq=1. A $4015 write then clears irq. A $4010 write with bit7=0 after re-raising irq also clears it.
REQ-020 Setup: loop=1, length 17 bytes; ack 17 fetches -> cur_addr reloads to start_addr, bytes_remaining=17, irq stays 0.
REQ-021 Setup: cur_addr=0xFFFF; ack -> next dma_addr=0x8000. Saturation: level=126 with all-ones data -> level holds at 126; level=1 with zeros -> level holds at 1.
REQ-022 Same-cycle events: $4011 write 0x7F plus step -> level=0x7F. $4015 disable plus dma_ack -> buffer_full=0, dma_req=0. reset asserted mid-request -> all REQ-016 values on the next edge.
